// File: rtl/register_file_8x16_pkg.sv
// Shared constants for the 8x16 register file: default geometry and the
// all-zero word that storage and read data return to on reset.
package register_file_8x16_pkg;

  localparam int DEFAULT_WIDTH         = 16;
  localparam int DEFAULT_DEPTH         = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 4;

  localparam logic [DEFAULT_WIDTH-1:0] RESET_WORD = '0;

endpackage

// File: rtl/register_file_8x16_if.sv
// Controller-side bus of the register file: address/enable/data request,
// registered read response, and the exported copies of entries 0..3.
interface register_file_8x16_if
  import register_file_8x16_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);

  logic [WIDTH-1:0]         WrData;
  logic [ADDRESS_WIDTH-1:0] Address;
  logic                     WrEn;
  logic                     RdEn;
  logic [WIDTH-1:0]         RdData;
  logic                     RdData_Valid;
  logic [WIDTH-1:0]         REG0;
  logic [WIDTH-1:0]         REG1;
  logic [WIDTH-1:0]         REG2;
  logic [WIDTH-1:0]         REG3;

  modport master (
    output WrData, Address, WrEn, RdEn,
    input  RdData, RdData_Valid, REG0, REG1, REG2, REG3
  );

  modport slave (
    input  WrData, Address, WrEn, RdEn,
    output RdData, RdData_Valid, REG0, REG1, REG2, REG3
  );

endinterface

// File: rtl/register_file_8x16.sv
// 8-entry x 16-bit register file with one shared address port, registered
// read data plus valid strobe, and entries 0..3 exported combinationally.
module register_file_8x16
  import register_file_8x16_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input logic                 CLK,
  input logic                 RST,
  register_file_8x16_if.slave bus
);

  localparam int INDEX_WIDTH = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] ZERO_WORD = WIDTH'(RESET_WORD);

  logic [WIDTH-1:0]       entries [DEPTH];
  logic [INDEX_WIDTH-1:0] index;
  logic                   inRange;
  logic                   wrAccept;
  logic                   rdAccept;

  // Out-of-range addresses must never alias onto a real entry, so the
  // truncated index is only trusted when the full address is below DEPTH.
  assign inRange  = 32'(bus.Address) < 32'(DEPTH);
  assign index    = bus.Address[INDEX_WIDTH-1:0];
  assign wrAccept = bus.WrEn && !bus.RdEn && inRange;
  assign rdAccept = bus.RdEn && !bus.WrEn;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= ZERO_WORD;
      end
    end else if (wrAccept) begin
      entries[index] <= bus.WrData;
    end
  end

  // Out-of-range reads still strobe valid so the requester's handshake completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.RdData       <= ZERO_WORD;
      bus.RdData_Valid <= 1'b0;
    end else begin
      bus.RdData_Valid <= rdAccept;
      if (rdAccept) begin
        bus.RdData <= inRange ? entries[index] : ZERO_WORD;
      end
    end
  end

  assign bus.REG0 = entries[0];
  assign bus.REG1 = entries[1];
  assign bus.REG2 = entries[2];
  assign bus.REG3 = entries[3];

endmodule

// File: tb/tb_register_file_8x16.sv
// Self-checking bench for register_file_8x16: a reference model of storage
// plus a queue of expected read responses popped whenever RdData_Valid rises.
module tb_register_file_8x16;

  logic CLK;
  logic RST;

  register_file_8x16_if #(.WIDTH(16), .ADDRESS_WIDTH(4)) bus ();

  register_file_8x16 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          testsRun;
  int          testsFailed;
  logic [15:0] modelMem [8];
  logic [15:0] modelRdData;
  logic [15:0] expQ [$];

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic checkRegs();
    checkOutput("REG0", bus.REG0, modelMem[0]);
    checkOutput("REG1", bus.REG1, modelMem[1]);
    checkOutput("REG2", bus.REG2, modelMem[2]);
    checkOutput("REG3", bus.REG3, modelMem[3]);
  endtask

  // Drive one request, update the model, clock it, then check the response
  // #1 after the edge so sampling never races the DUT.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] addr,
                               input logic [15:0] data);
    logic readAccepted;
    bus.WrEn    = wr;
    bus.RdEn    = rd;
    bus.Address = addr;
    bus.WrData  = data;
    readAccepted = rd && !wr;
    if (readAccepted) expQ.push_back((addr < 4'd8) ? modelMem[addr[2:0]] : 16'h0000);
    @(posedge CLK);
    #1;
    if (wr && !rd && addr < 4'd8) modelMem[addr[2:0]] = data;
    checkOutput("RdData_Valid", 16'(bus.RdData_Valid), 16'(readAccepted));
    if (bus.RdData_Valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_read", bus.RdData, 16'hDEAD);
      end else begin
        modelRdData = expQ.pop_front();
        checkOutput("RdData", bus.RdData, modelRdData);
      end
    end else begin
      checkOutput("RdData_held", bus.RdData, modelRdData);
    end
    checkRegs();
  endtask

  task automatic idle();
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelRdData = 16'h0000;
    for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
    bus.WrEn    = 1'b0;
    bus.RdEn    = 1'b0;
    bus.Address = 4'd0;
    bus.WrData  = 16'h0000;

    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("reset_RdData", bus.RdData, 16'h0000);
    checkOutput("reset_Valid", 16'(bus.RdData_Valid), 16'h0000);
    checkRegs();

    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0002);
    applyStimulus(1'b1, 1'b0, 4'd1, 16'h0004);

    applyStimulus(1'b0, 1'b1, 4'd0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 4'd1, 16'h0000);

    // Populate entries 4..7 so the out-of-range write can prove no aliasing.
    applyStimulus(1'b1, 1'b0, 4'd4, 16'h1111);
    applyStimulus(1'b1, 1'b0, 4'd5, 16'h2222);
    applyStimulus(1'b1, 1'b0, 4'd6, 16'h3333);
    applyStimulus(1'b1, 1'b0, 4'd7, 16'h4444);
    applyStimulus(1'b1, 1'b0, 4'd8, 16'h0006);
    applyStimulus(1'b1, 1'b0, 4'd12, 16'h0BAD);
    for (int a = 4; a < 8; a++) applyStimulus(1'b0, 1'b1, 4'(a), 16'h0000);
    applyStimulus(1'b0, 1'b1, 4'd8, 16'h0000);
    applyStimulus(1'b0, 1'b1, 4'd15, 16'h0000);
    applyStimulus(1'b0, 1'b1, 4'd0, 16'h0000);

    applyStimulus(1'b1, 1'b1, 4'd2, 16'h55AA);
    applyStimulus(1'b0, 1'b1, 4'd2, 16'h0000);

    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 16'($urandom));
    end

    applyStimulus(1'b1, 1'b0, 4'd3, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h0000);
    idle();
    #2;
    RST = 1'b0;
    #1;
    checkOutput("midreset_REG3", bus.REG3, 16'h0000);
    checkOutput("midreset_RdData", bus.RdData, 16'h0000);
    checkOutput("midreset_Valid", 16'(bus.RdData_Valid), 16'h0000);
    for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
    modelRdData = 16'h0000;
    expQ.delete();
    @(negedge CLK);
    RST = 1'b1;
    for (int a = 4; a < 8; a++) applyStimulus(1'b0, 1'b1, 4'(a), 16'h0000);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
